// File: rtl/mypackage.sv
// Shared fixed-point types for the audio path, plus the waveform and
// sequencing definitions used by the multi-voice NCO.
package mypackage;

    localparam int unsigned FREQUENCY_FRACTIONAL_BITS = 8;
    localparam int unsigned FREQUENCY_BITS            = 24;
    localparam int unsigned AMPLITUDE_BITS            = 16;

    typedef logic [FREQUENCY_BITS-1:0]        frequency;
    typedef logic signed [AMPLITUDE_BITS-1:0] amplitude;

    localparam int unsigned NCO_DEFAULT_PHASE_BITS = 32;

    typedef logic [NCO_DEFAULT_PHASE_BITS-1:0] nco_phase_t;

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        SINE     = 3'd1,
        SAW      = 3'd2,
        SQUARE   = 3'd3,
        TRIANGLE = 3'd4
    } waveform_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } nco_state_t;

endpackage

// File: rtl/nco_poly_sine_rom.sv
// Quarter-wave sine magnitude ROM, one-cycle registered read.
// Entry 0 is sin(0); the last entry approaches full scale.
module nco_sine_rom #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned AMP_BITS  = 16
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [AMP_BITS-2:0]  data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    // Elaboration-time Taylor series keeps the table free of $sin support.
    function automatic logic [AMP_BITS-2:0] entry(input int unsigned idx);
        real x;
        real term;
        real acc;
        real scaled;
        x    = 1.5707963267948966 * real'(idx) / real'(DEPTH);
        term = x;
        acc  = x;
        for (int unsigned k = 1; k < 9; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        scaled = acc * (2.0 ** (AMP_BITS - 1) - 1.0) + 0.5;
        return (AMP_BITS-1)'($rtoi(scaled));
    endfunction

    logic [AMP_BITS-2:0] rom_data [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom_data[i] = entry(i);
    end

    always_ff @(posedge clock) begin
        data <= rom_data[addr];
    end

endmodule

// File: rtl/nco_poly.sv
// Time-multiplexed multi-voice NCO: one shared phase/waveform pipeline
// walks every voice per sample_tick, then emits a saturated mix.
module nco_poly
    import mypackage::*;
#(
    parameter int unsigned VOICES         = 8,
    parameter int unsigned PHASE_BITS     = NCO_DEFAULT_PHASE_BITS,
    parameter int unsigned SAMPLE_RATE_HZ = 48000,
    parameter int unsigned SINE_ADDR_BITS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      sample_tick,
    input  logic                      cfg_we,
    input  logic [$clog2(VOICES)-1:0] cfg_voice,
    input  frequency                  cfg_freq,
    input  waveform_t                 cfg_wave,
    input  logic                      cfg_sync,
    output amplitude                  out,
    output logic                      out_valid,
    output logic [$clog2(VOICES)-1:0] out_voice,
    output amplitude                  mix,
    output logic                      mix_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned VW          = $clog2(VOICES);
    localparam int unsigned A           = $bits(amplitude);
    localparam int unsigned FW          = $bits(frequency);
    localparam int unsigned RECIP_SHIFT = 32;
    localparam int unsigned RW          = PHASE_BITS + RECIP_SHIFT + 1;
    localparam int unsigned PW          = FW + RW;
    localparam int unsigned MW          = A + VW + 1;

    // 2^(PHASE_BITS+RECIP_SHIFT)/rate is exact for power-of-two rates.
    localparam logic [RW-1:0] RECIP_ONE = RW'(1) << (RW - 1);
    localparam logic [RW-1:0] RECIP     = RECIP_ONE / RW'(SAMPLE_RATE_HZ);

    localparam logic [VW-1:0]        LAST_VOICE = VW'(VOICES - 1);
    localparam amplitude             MAX_AMP    = {1'b0, {(A-1){1'b1}}};
    localparam amplitude             MIN_AMP    = {1'b1, {(A-1){1'b0}}};
    localparam logic signed [MW-1:0] SAT_HI     = MW'(MAX_AMP);
    localparam logic signed [MW-1:0] SAT_LO     = MW'(MIN_AMP);

    logic [PHASE_BITS-1:0] phase [VOICES];
    logic [PHASE_BITS-1:0] inc   [VOICES];
    waveform_t             wave  [VOICES];

    logic [PW-1:0]         prod;
    logic [PHASE_BITS-1:0] inc_new;

    nco_state_t  state, state_next;
    logic [VW-1:0] s0_voice;
    logic          s0_valid;
    logic          accept;

    logic [PHASE_BITS-1:0]     rd_phase;
    logic [SINE_ADDR_BITS-1:0] rd_idx;
    logic [SINE_ADDR_BITS-1:0] rom_addr;
    logic [A-2:0]              rom_q;

    logic                  s1_valid, s1_first, s1_last;
    logic [VW-1:0]         s1_voice;
    logic [PHASE_BITS-1:0] s1_phase, s1_inc;
    waveform_t             s1_wave;

    logic [A-1:0] p1;
    amplitude     tri_ramp, tri_mag, sine_mag, sample;

    logic                 out_last;
    logic signed [MW-1:0] acc;
    amplitude             mix_sat;

    always_comb begin
        prod    = PW'(cfg_freq) * PW'(RECIP);
        inc_new = PHASE_BITS'(prod >> (RECIP_SHIFT + FREQUENCY_FRACTIONAL_BITS));
    end

    assign accept   = sample_tick && enable && (state == ST_IDLE);
    assign s0_valid = (state == ST_SCAN);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SCAN;
            ST_SCAN:  if (s0_voice == LAST_VOICE) state_next = ST_DRAIN;
            ST_DRAIN: if (out_valid && out_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || state != ST_SCAN) s0_voice <= '0;
        else                           s0_voice <= s0_voice + VW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)                          overrun <= 1'b0;
        else if (sample_tick && enable && busy) overrun <= 1'b1;
    end

    // Stage 0: read voice state; sine address mirrors in quadrants 1 and 3.
    always_comb begin
        rd_phase = phase[s0_voice];
        rd_idx   = SINE_ADDR_BITS'(rd_phase >> (PHASE_BITS - 2 - SINE_ADDR_BITS));
        rom_addr = rd_phase[PHASE_BITS-2] ? ~rd_idx : rd_idx;
    end

    nco_sine_rom #(
        .ADDR_BITS(SINE_ADDR_BITS),
        .AMP_BITS (A)
    ) u_rom (
        .clock(clock),
        .addr (rom_addr),
        .data (rom_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            s1_first <= s0_valid && (s0_voice == '0);
            s1_last  <= s0_valid && (s0_voice == LAST_VOICE);
        end
        s1_voice <= s0_voice;
        s1_phase <= rd_phase;
        s1_inc   <= inc[s0_voice];
        s1_wave  <= wave[s0_voice];
    end

    // A config sync is ordered after the pipeline write so it wins on collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
                wave[i]  <= OFF;
            end
        end else begin
            if (s1_valid) phase[s1_voice] <= s1_phase + s1_inc;
            if (cfg_we) begin
                inc[cfg_voice]  <= inc_new;
                wave[cfg_voice] <= cfg_wave;
                if (cfg_sync) phase[cfg_voice] <= '0;
            end
        end
    end

    // Stage 1: waveform from the pre-increment phase.
    always_comb begin
        p1       = s1_phase[PHASE_BITS-1 -: A];
        tri_ramp = {1'b0, p1[A-3:0], 1'b0};
        tri_mag  = p1[A-2] ? (MAX_AMP - tri_ramp) : tri_ramp;
        sine_mag = {1'b0, rom_q};
        sample   = '0;
        case (s1_wave)
            SINE:     sample = p1[A-1] ? -sine_mag : sine_mag;
            SAW:      sample = {~p1[A-1], p1[A-2:0]};
            SQUARE:   sample = p1[A-1] ? -MAX_AMP : MAX_AMP;
            TRIANGLE: sample = p1[A-1] ? -tri_mag : tri_mag;
            default:  sample = '0;
        endcase
    end

    always_comb begin
        if (acc > SAT_HI)      mix_sat = MAX_AMP;
        else if (acc < SAT_LO) mix_sat = MIN_AMP;
        else                   mix_sat = acc[A-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_voice <= '0;
            out_last  <= 1'b0;
            acc       <= '0;
            mix       <= '0;
            mix_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            mix_valid <= out_valid && out_last;
            if (s1_valid) begin
                out       <= sample;
                out_voice <= s1_voice;
                acc       <= (s1_first ? '0 : acc) + MW'(sample);
            end
            if (out_valid && out_last) mix <= mix_sat;
        end
    end

endmodule
